// File: rtl/dmem_pkg.sv
// dmem_pkg: shared defaults, state encoding and sizing helper
// for the data-memory arbiter slice.
package dmem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;
  localparam int DEPTH_DEF  = 1024;
  localparam int CLR_CNT_W  = $clog2(DEPTH_DEF);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } dmem_state_t;

  function automatic int cnt_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin arbiter, one-hot grant.
// The pointer always moves to the loser after any grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= 1'b0;
    else if (|gnt)
      ptr <= gnt[0];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: clears data memory after reset, then shares the
// port between the LSU (m0) and DMA/debug (m1) round-robin.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DEPTH          = DEPTH_DEF,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = cnt_w(DEPTH);
  localparam dmem_state_t RST_ST =
    dmem_state_t'(CLEAR_ON_RESET ? ST_CLEAR : ST_RUN);

  dmem_state_t   state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    gnt;
  logic          m0_ok, m1_ok;
  logic          we_c;

  assign m0_ok = m0_addr < ADDR_W'(DEPTH);
  assign m1_ok = m1_addr < ADDR_W'(DEPTH);

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  ((state == ST_RUN) & ~rst),
    .req ({m1_req, m0_req}),
    .gnt (gnt)
  );

  assign m0_gnt     = gnt[0];
  assign m1_gnt     = gnt[1];
  assign clear_busy = (state == ST_CLEAR);
  assign mem_we     = we_c & ~rst;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    we_c      = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      ST_CLEAR: begin
        we_c     = 1'b1;
        mem_addr = ADDR_W'(cnt);
        cnt_nx   = cnt + 1'b1;
        if (cnt == CW'(DEPTH - 1)) begin
          state_nx = ST_RUN;
          cnt_nx   = '0;
        end
      end
      ST_RUN: begin
        unique case (1'b1)
          gnt[0]: begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            we_c      = m0_we & m0_ok;
          end
          gnt[1]: begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            we_c      = m1_we & m1_ok;
          end
          default: ;
        endcase
      end
      default: state_nx = RST_ST;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RST_ST;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Out-of-range reads return zero rather than whatever the port shows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_rvalid <= 1'b0;
      m1_err    <= 1'b0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= gnt[0] & ~m0_we;
      m0_err    <= gnt[0] & ~m0_ok;
      m1_rvalid <= gnt[1] & ~m1_we;
      m1_err    <= gnt[1] & ~m1_ok;
      if (gnt[0] & ~m0_we)
        m0_rdata <= m0_ok ? mem_rdata : '0;
      if (gnt[1] & ~m1_we)
        m1_rdata <= m1_ok ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of clear, arbitration, reads,
// range errors and reset restart with a 16-word memory.
module tb_dmem_arbiter;

  logic        clk, rst;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        clear_busy, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int passed = 0;

  logic [31:0] mem [16];
  logic        fill;

  dmem_arbiter #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(16), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .clear_busy(clear_busy), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model, preloaded with non-zero junk so the clear is visible.
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 16; i++)
        mem[i] <= 32'hA5A50000 + 32'(i);
    end else if (mem_we && mem_addr < 32'd16) begin
      mem[mem_addr[3:0]] <= mem_wdata;
    end
  end

  assign mem_rdata = (mem_addr < 32'd16) ? mem[mem_addr[3:0]] : 32'hFFFFFFFF;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic test_reset();
    idle();
    fill = 1;
    step();
    step();
    fill = 0;
    step();
    total++;
    if ({clear_busy, mem_we} !== 2'b10)
      $display("FAIL rst_busy_we: got %b want 10", {clear_busy, mem_we});
    else passed++;
    total++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err} !== 6'b0)
      $display("FAIL rst_flags: got %b want 000000",
               {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err});
    else passed++;
    total++;
    if ({m0_rdata, m1_rdata} !== 64'h0)
      $display("FAIL rst_rdata: got %h want 0", {m0_rdata, m1_rdata});
    else passed++;
  endtask

  task automatic test_clear_hold_off();
    m0_req = 1; m0_addr = 5;
    rst = 0;
    #1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if ({clear_busy, mem_we, m0_gnt, mem_addr, mem_wdata} !==
          {1'b1, 1'b1, 1'b0, 32'(i), 32'h0})
        $display("FAIL clear_%0d: got busy%b we%b gnt%b a%h d%h want 110 a%h d0",
                 i, clear_busy, mem_we, m0_gnt, mem_addr, mem_wdata, i);
      else passed++;
      step();
    end
    total++;
    if ({clear_busy, m0_gnt, mem_we, mem_addr} !== {3'b010, 32'd5})
      $display("FAIL first_run: got busy%b gnt%b we%b a%h want 010 a5",
               clear_busy, m0_gnt, mem_we, mem_addr);
    else passed++;
    step();
    m0_req = 0;
    total++;
    if ({m0_rvalid, m0_err, m0_rdata} !== {2'b10, 32'h0})
      $display("FAIL read5: got v%b e%b d%h want 10 d0",
               m0_rvalid, m0_err, m0_rdata);
    else passed++;
  endtask

  task automatic test_write_read();
    m0_req = 1; m0_we = 1; m0_addr = 0; m0_wdata = 32'h1488;
    #1;
    total++;
    if ({m0_gnt, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h0, 32'h1488})
      $display("FAIL wr_port: got g%b we%b a%h d%h want 11 a0 d1488",
               m0_gnt, mem_we, mem_addr, mem_wdata);
    else passed++;
    step();
    m0_we = 0; m0_wdata = 0;
    #1;
    total++;
    if ({m0_gnt, mem_we, m0_rvalid} !== 3'b100)
      $display("FAIL rd_gnt: got g%b we%b v%b want 100",
               m0_gnt, mem_we, m0_rvalid);
    else passed++;
    step();
    m0_req = 0;
    total++;
    if ({m0_rvalid, m0_err, m0_rdata} !== {2'b10, 32'h1488})
      $display("FAIL rd_data: got v%b e%b d%h want 10 d1488",
               m0_rvalid, m0_err, m0_rdata);
    else passed++;
    step();
    total++;
    if ({m0_rvalid, m0_rdata} !== {1'b0, 32'h1488})
      $display("FAIL rd_hold: got v%b d%h want 0 d1488", m0_rvalid, m0_rdata);
    else passed++;
  endtask

  task automatic test_alternate();
    logic [1:0] eg, ev;
    m1_req = 1; m1_we = 1; m1_addr = 3; m1_wdata = 32'h3333;
    #1;
    total++;
    if ({m1_gnt, m0_gnt, mem_we} !== 3'b101)
      $display("FAIL m1_wr: got %b want 101", {m1_gnt, m0_gnt, mem_we});
    else passed++;
    step();
    m1_we = 0; m1_wdata = 0;
    m0_req = 1; m0_addr = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
      ev = (k == 0) ? 2'b00 : ((k % 2 == 0) ? 2'b10 : 2'b01);
      total++;
      if ({m1_gnt, m0_gnt, mem_addr} !== {eg, (k % 2 == 0) ? 32'd0 : 32'd3})
        $display("FAIL alt_gnt_%0d: got %b a%h want %b", k,
                 {m1_gnt, m0_gnt}, mem_addr, eg);
      else passed++;
      total++;
      if ({m1_rvalid, m0_rvalid} !== ev)
        $display("FAIL alt_rv_%0d: got %b want %b", k,
                 {m1_rvalid, m0_rvalid}, ev);
      else passed++;
      if (k > 0) begin
        total++;
        if ((k % 2 == 1 && m0_rdata !== 32'h1488) ||
            (k % 2 == 0 && m1_rdata !== 32'h3333))
          $display("FAIL alt_rd_%0d: got m0 %h m1 %h want 1488/3333",
                   k, m0_rdata, m1_rdata);
        else passed++;
      end
      step();
    end
    m0_req = 0; m1_req = 0;
    total++;
    if ({m1_rvalid, m0_rvalid, m1_rdata, m0_rdata} !==
        {2'b10, 32'h3333, 32'h1488})
      $display("FAIL alt_last: got v%b m1 %h m0 %h want 10 3333 1488",
               {m1_rvalid, m0_rvalid}, m1_rdata, m0_rdata);
    else passed++;
  endtask

  task automatic test_out_of_range();
    m1_req = 1; m1_we = 0; m1_addr = 16;
    #1;
    total++;
    if ({m1_gnt, mem_we, mem_addr} !== {2'b10, 32'd16})
      $display("FAIL oor_rd_port: got g%b we%b a%h want 10 a10",
               m1_gnt, mem_we, mem_addr);
    else passed++;
    step();
    m1_we = 1; m1_addr = 2000; m1_wdata = 32'hDEAD;
    #1;
    total++;
    if ({m1_rvalid, m1_err, m1_rdata} !== {2'b11, 32'h0})
      $display("FAIL oor_rd_ret: got v%b e%b d%h want 11 d0",
               m1_rvalid, m1_err, m1_rdata);
    else passed++;
    total++;
    if ({m1_gnt, mem_we, mem_addr, mem_wdata} !== {2'b10, 32'd2000, 32'hDEAD})
      $display("FAIL oor_wr_port: got g%b we%b a%h d%h want 10 a7d0 dDEAD",
               m1_gnt, mem_we, mem_addr, mem_wdata);
    else passed++;
    step();
    m1_req = 0; m1_we = 0; m1_wdata = 0;
    total++;
    if ({m1_err, m1_rvalid, m1_rdata} !== {2'b10, 32'h0})
      $display("FAIL oor_wr_err: got e%b v%b d%h want 10 d0",
               m1_err, m1_rvalid, m1_rdata);
    else passed++;
    step();
    total++;
    if (m1_err !== 1'b0)
      $display("FAIL oor_err_pulse: got %b want 0", m1_err);
    else passed++;
    m0_req = 1; m0_addr = 15;
    #1;
    total++;
    if ({m0_gnt, mem_addr} !== {1'b1, 32'd15})
      $display("FAIL edge_gnt: got g%b a%h want 1 af", m0_gnt, mem_addr);
    else passed++;
    step();
    m0_req = 0;
    total++;
    if ({m0_rvalid, m0_err, m0_rdata} !== {2'b10, 32'h0})
      $display("FAIL edge_rd: got v%b e%b d%h want 10 d0",
               m0_rvalid, m0_err, m0_rdata);
    else passed++;
  endtask

  task automatic test_same_addr();
    m0_req = 1; m0_we = 1; m0_addr = 7; m0_wdata = 32'hCAFE;
    #1;
    total++;
    if ({m0_gnt, mem_we} !== 2'b11)
      $display("FAIL raw_wr: got %b want 11", {m0_gnt, mem_we});
    else passed++;
    step();
    m0_req = 0; m0_we = 0; m0_wdata = 0;
    m1_req = 1; m1_addr = 7;
    #1;
    total++;
    if ({m1_gnt, mem_we} !== 2'b10)
      $display("FAIL raw_rd: got %b want 10", {m1_gnt, mem_we});
    else passed++;
    step();
    m1_req = 0;
    total++;
    if ({m1_rvalid, m1_rdata} !== {1'b1, 32'hCAFE})
      $display("FAIL raw_data: got v%b d%h want 1 dCAFE", m1_rvalid, m1_rdata);
    else passed++;
  endtask

  task automatic test_reset_mid_clear();
    m0_req = 1; m0_addr = 7;
    #1;
    total++;
    if (m0_gnt !== 1'b1)
      $display("FAIL inflight_gnt: got %b want 1", m0_gnt);
    else passed++;
    #1 rst = 1;
    #1;
    total++;
    if ({m0_gnt, m1_gnt, mem_we, clear_busy} !== 4'b0001)
      $display("FAIL rst_async: got %b want 0001",
               {m0_gnt, m1_gnt, mem_we, clear_busy});
    else passed++;
    m0_req = 0;
    step();
    step();
    total++;
    if ({m0_rvalid, m1_rvalid, m0_err, m1_err, m0_rdata, m1_rdata} !== 68'h0)
      $display("FAIL rst_drop: got v%b%b e%b%b d%h %h want all 0",
               m0_rvalid, m1_rvalid, m0_err, m1_err, m0_rdata, m1_rdata);
    else passed++;
    rst = 0;
    #1;
    for (int i = 0; i < 7; i++) begin
      total++;
      if ({clear_busy, mem_we, mem_addr} !== {2'b11, 32'(i)})
        $display("FAIL clr_a_%0d: got b%b we%b a%h want 11 a%h",
                 i, clear_busy, mem_we, mem_addr, i);
      else passed++;
      step();
    end
    total++;
    if (mem_addr !== 32'd7)
      $display("FAIL clr_at7: got %h want 7", mem_addr);
    else passed++;
    #1 rst = 1;
    #1;
    total++;
    if ({mem_we, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err} !== 7'b0)
      $display("FAIL rst_mid: got %b want 0000000",
               {mem_we, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err});
    else passed++;
    step();
    step();
    rst = 0;
    #1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if ({clear_busy, mem_we, mem_addr, mem_wdata} !==
          {2'b11, 32'(i), 32'h0})
        $display("FAIL clr_b_%0d: got b%b we%b a%h d%h want 11 a%h d0",
                 i, clear_busy, mem_we, mem_addr, mem_wdata, i);
      else passed++;
      step();
    end
    total++;
    if (clear_busy !== 1'b0)
      $display("FAIL clr_done: got %b want 0", clear_busy);
    else passed++;
  endtask

  initial begin
    rst = 1;
    fill = 0;
    idle();
    test_reset();
    test_clear_hold_off();
    test_write_read();
    test_alternate();
    test_out_of_range();
    test_same_addr();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
